// File: rtl/pipeline_control_if.sv
// Stall/flush control bundle between the LEGv8 pipeline datapath and pipeline_control.
// PIPELINE_PERF_EN adds the performance counter outputs.
interface pipeline_control_if #(
  parameter int COUNTERSIZE = 3
);
  logic                   stall_req;
  logic                   branch_taken;
  logic                   mem_busy;
  logic                   hlt_id;
  logic [COUNTERSIZE-1:0] stage;
  logic                   pc_write;
  logic                   ifid_write;
  logic                   ifid_flush;
  logic                   idex_bubble;
  logic                   exmem_flush;
  logic                   pipe_en;
  logic                   halted;
`ifdef PIPELINE_PERF_EN
  logic [15:0]            stall_cycles;
  logic [15:0]            flush_count;
  logic [15:0]            freeze_cycles;

  modport master (
    output stall_req, branch_taken, mem_busy, hlt_id,
    input  stage, pc_write, ifid_write, ifid_flush, idex_bubble,
           exmem_flush, pipe_en, halted,
           stall_cycles, flush_count, freeze_cycles
  );

  modport slave (
    input  stall_req, branch_taken, mem_busy, hlt_id,
    output stage, pc_write, ifid_write, ifid_flush, idex_bubble,
           exmem_flush, pipe_en, halted,
           stall_cycles, flush_count, freeze_cycles
  );
`else
  modport master (
    output stall_req, branch_taken, mem_busy, hlt_id,
    input  stage, pc_write, ifid_write, ifid_flush, idex_bubble,
           exmem_flush, pipe_en, halted
  );

  modport slave (
    input  stall_req, branch_taken, mem_busy, hlt_id,
    output stage, pc_write, ifid_write, ifid_flush, idex_bubble,
           exmem_flush, pipe_en, halted
  );
`endif
endinterface

// File: rtl/pipeline_control.sv
// Central stall/flush/halt sequencer for the 5-stage LEGv8 pipeline.
// Optional PIPELINE_PERF_EN adds saturating stall/flush/freeze cycle counters.
module pipeline_control #(
  parameter int COUNTERSIZE  = 3,
  parameter int STAGE_MAX    = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  pipeline_control_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]          DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [COUNTERSIZE-1:0] STAGE_SAT  = COUNTERSIZE'(STAGE_MAX);
  localparam logic [COUNTERSIZE-1:0] STAGE_ONE  = COUNTERSIZE'(1);

  state_t                 state_q, state_d;
  logic [COUNTERSIZE-1:0] stage_q, stage_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic                   halted_q;

  logic pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_en;
  logic do_flush, do_stall, do_freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      stage_q  <= '0;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == HALTED);
    end
  end

  // Priority: mem_busy > branch_taken > hlt_id > stall_req; a branch squashes younger requests.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    pipe_en     = 1'b0;
    do_flush    = 1'b0;
    do_stall    = 1'b0;
    do_freeze   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.mem_busy) begin
          do_freeze = 1'b1;
        end else if (bus.branch_taken) begin
          do_flush = 1'b1;
        end else if (bus.hlt_id) begin
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          pipe_en    = 1'b1;
          state_d    = DRAIN;
          drain_d    = DRAIN_LOAD;
        end else if (bus.stall_req && (stage_q > STAGE_ONE)) begin
          idex_bubble = 1'b1;
          pipe_en     = 1'b1;
          do_stall    = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          pipe_en    = 1'b1;
        end
      end
      DRAIN: begin
        if (bus.mem_busy) begin
          do_freeze = 1'b1;
        end else if (bus.branch_taken) begin
          do_flush = 1'b1;
          state_d  = RUN;
          drain_d  = '0;
        end else begin
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          pipe_en    = 1'b1;
          if (drain_q == '0) state_d = HALTED;
          else               drain_d = drain_q - DW'(1);
        end
      end
      HALTED: begin
      end
      default: state_d = RUN;
    endcase

    if (do_flush) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      pipe_en     = 1'b1;
    end

    // Hold every control low while reset is asserted, even mid-drain.
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      pipe_en     = 1'b0;
      do_flush    = 1'b0;
      do_stall    = 1'b0;
      do_freeze   = 1'b0;
    end
  end

  always_comb begin
    stage_d = stage_q;
    if (do_flush)                           stage_d = STAGE_ONE;
    else if (pipe_en && stage_q < STAGE_SAT) stage_d = stage_q + STAGE_ONE;
  end

  assign bus.stage       = stage_q;
  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.exmem_flush = exmem_flush;
  assign bus.pipe_en     = pipe_en;
  assign bus.halted      = halted_q;

`ifdef PIPELINE_PERF_EN
  logic [15:0] stall_cycles_q, flush_count_q, freeze_cycles_q;

  // Event strobes are already zero in HALTED, so the counters freeze there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q  <= '0;
      flush_count_q   <= '0;
      freeze_cycles_q <= '0;
    end else begin
      if (do_stall  && stall_cycles_q  != 16'hFFFF) stall_cycles_q  <= stall_cycles_q  + 16'd1;
      if (do_flush  && flush_count_q   != 16'hFFFF) flush_count_q   <= flush_count_q   + 16'd1;
      if (do_freeze && freeze_cycles_q != 16'hFFFF) freeze_cycles_q <= freeze_cycles_q + 16'd1;
    end
  end

  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.flush_count   = flush_count_q;
  assign bus.freeze_cycles = freeze_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: directed per-cycle vectors with hand-computed outputs.
module tb_pipeline_control;

  // Output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_en, halted}
  localparam logic [6:0] ZERO  = 7'b0000000;
  localparam logic [6:0] IDLE  = 7'b1100010;
  localparam logic [6:0] STALL = 7'b0001010;
  localparam logic [6:0] FLUSH = 7'b1111110;
  localparam logic [6:0] FRZ   = 7'b0000000;
  localparam logic [6:0] DRN   = 7'b0110010;
  localparam logic [6:0] HALT  = 7'b0000001;

  typedef struct {
    int         row;
    logic [6:0] outs;
    logic [2:0] stage;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   row = 0;
  int   checks = 0;
  int   failures = 0;

  pipeline_control_if #(.COUNTERSIZE(3)) bus ();

  pipeline_control #(
    .COUNTERSIZE(3),
    .STAGE_MAX(5),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int r,
                             input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, r, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic stall, input logic br,
                               input logic busy, input logic hlt,
                               input logic [6:0] exp_outs, input logic [2:0] exp_stage);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n            = rst;
    bus.stall_req    = stall;
    bus.branch_taken = br;
    bus.mem_busy     = busy;
    bus.hlt_id       = hlt;
    row++;
    e.row   = row;
    e.outs  = exp_outs;
    e.stage = exp_stage;
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT against the scoreboard mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("outs", e.row,
                    {9'd0, bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble,
                     bus.exmem_flush, bus.pipe_en, bus.halted},
                    {9'd0, e.outs});
        checkOutput("stage", e.row, {13'd0, bus.stage}, {13'd0, e.stage});
      end
    end
  end

  initial begin
    bus.stall_req    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_busy     = 1'b0;
    bus.hlt_id       = 1'b0;

    //            rst stl br  bsy hlt  outs   stage
    applyStimulus(0, 0, 0, 0, 0, ZERO,  3'd0);
    applyStimulus(0, 0, 0, 0, 0, ZERO,  3'd0);
    // Fill: stage 0..5 then saturate
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd0);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd1);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd2);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd3);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd4);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd5);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd5);
    // Load-use stall at full pipeline
    applyStimulus(1, 1, 0, 0, 0, STALL, 3'd5);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd5);
    // Branch beats stall, then stall at stage 1 is ignored, stall at stage 2 honoured
    applyStimulus(1, 1, 1, 0, 0, FLUSH, 3'd5);
    applyStimulus(1, 1, 0, 0, 0, IDLE,  3'd1);
    applyStimulus(1, 1, 0, 0, 0, STALL, 3'd2);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd3);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd4);
    // Branch held under mem_busy, flush when busy drops
    applyStimulus(1, 0, 1, 1, 0, FRZ,   3'd5);
    applyStimulus(1, 0, 1, 1, 0, FRZ,   3'd5);
    applyStimulus(1, 0, 1, 0, 0, FLUSH, 3'd5);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd1);
    applyStimulus(1, 1, 0, 1, 0, FRZ,   3'd2);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd2);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd3);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd4);
    // HLT with one freeze mid-drain: halted on the 5th cycle after HLT
    applyStimulus(1, 0, 0, 0, 1, DRN,   3'd5);
    applyStimulus(1, 0, 0, 0, 0, DRN,   3'd5);
    applyStimulus(1, 0, 0, 1, 0, FRZ,   3'd5);
    applyStimulus(1, 0, 0, 0, 0, DRN,   3'd5);
    applyStimulus(1, 0, 0, 0, 0, DRN,   3'd5);
    applyStimulus(1, 0, 0, 0, 0, HALT,  3'd5);
    applyStimulus(1, 1, 1, 0, 1, HALT,  3'd5);
    applyStimulus(1, 0, 0, 1, 0, HALT,  3'd5);
    // Only reset leaves HALTED
    applyStimulus(0, 0, 0, 0, 0, ZERO,  3'd0);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd0);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd1);
    // Older branch on drain cycle 2 cancels the halt
    applyStimulus(1, 0, 0, 0, 1, DRN,   3'd2);
    applyStimulus(1, 0, 0, 0, 0, DRN,   3'd3);
    applyStimulus(1, 0, 1, 0, 0, FLUSH, 3'd4);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd1);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd2);
    // Reset asserted mid-drain with live inputs
    applyStimulus(1, 0, 0, 0, 1, DRN,   3'd3);
    applyStimulus(1, 0, 0, 0, 0, DRN,   3'd4);
    applyStimulus(0, 1, 1, 0, 1, ZERO,  3'd0);
`ifdef PIPELINE_PERF_EN
    #1;
    checkOutput("stall_cycles",  row, bus.stall_cycles,  16'd0);
    checkOutput("flush_count",   row, bus.flush_count,   16'd0);
    checkOutput("freeze_cycles", row, bus.freeze_cycles, 16'd0);
`endif
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd0);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd1);
    applyStimulus(1, 0, 0, 0, 0, IDLE,  3'd2);

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", row, exp_q.size(), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
